mem_port_arbiter: RTL and testbench

- Shares the single 16-bit memory port between two requesters: the instruction-fetch path and the load/store data path of the CPU core.
- Data accesses have priority. A streak counter guarantees fetch forward progress.
- Read data returns a fixed RD_LATENCY cycles after the command. A tag pipeline steers each returning word to the requester that issued the read.
- Sits between the CPU core and the memory, replacing the core's direct drive of the memory port.

---
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and data paths. Data wins unless
// fetch has lost MAX_DATA_STREAK contended grants in a row.
module mem_port_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int RD_LATENCY      = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wrdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wrdata,
    input  logic [DATA_W-1:0] i_mem_rddata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0]            streak;
    logic                  force_if;
    logic [RD_LATENCY-1:0] tag_v;
    logic [RD_LATENCY-1:0] tag_d;

    assign force_if = if_req && (streak == STREAK_MAX);
    assign if_gnt   = if_req && (!d_req || force_if);
    assign d_gnt    = d_req && !force_if;

    always_comb begin
        o_mem_addr   = '0;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_wrdata = '0;
        if (d_gnt) begin
            o_mem_addr   = d_addr;
            o_mem_wr     = d_we;
            o_mem_rd     = !d_we;
            o_mem_wrdata = d_wrdata;
        end else if (if_gnt) begin
            o_mem_addr = if_addr;
            o_mem_rd   = 1'b1;
        end
    end

    // Only data grants that made fetch wait are counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (d_gnt && if_req) begin
            if (streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end
        end else if (if_gnt || !if_req) begin
            streak <= '0;
        end
    end

    // Tag pipeline mirrors the memory read latency; writes enter as invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            tag_d <= '0;
        end else begin
            tag_v[0] <= o_mem_rd;
            tag_d[0] <= d_gnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_d[i] <= tag_d[i-1];
            end
        end
    end

    assign if_rvalid = tag_v[RD_LATENCY-1] && !tag_d[RD_LATENCY-1];
    assign d_rvalid  = tag_v[RD_LATENCY-1] && tag_d[RD_LATENCY-1];
    assign if_rdata  = if_rvalid ? i_mem_rddata : '0;
    assign d_rdata   = d_rvalid ? i_mem_rddata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at read latency 1 and one
// at latency 3, each fed by its own delayed-read memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wrdata;

    logic        if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_rd_1, mem_wr_1;
    logic [15:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wrdata_1, mem_rddata_1;
    logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_rd_3, mem_wr_3;
    logic [15:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_wrdata_3, mem_rddata_3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RD_LATENCY(1), .MAX_DATA_STREAK(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1),
        .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wrdata(d_wrdata),
        .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .o_mem_addr(mem_addr_1), .o_mem_rd(mem_rd_1), .o_mem_wr(mem_wr_1),
        .o_mem_wrdata(mem_wrdata_1), .i_mem_rddata(mem_rddata_1)
    );

    mem_port_arbiter #(.RD_LATENCY(3), .MAX_DATA_STREAK(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
        .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wrdata(d_wrdata),
        .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
        .o_mem_addr(mem_addr_3), .o_mem_rd(mem_rd_3), .o_mem_wr(mem_wr_3),
        .o_mem_wrdata(mem_wrdata_3), .i_mem_rddata(mem_rddata_3)
    );

    // Memory model: contents mem[i] = 0x0100 + i, except two marked words.
    // Cycles without a read return 0xDEAD so unqualified rdata shows up.
    logic [15:0] mem [0:255];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [0:2];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        mem[8'h40] = 16'h1234;
        mem[8'h10] = 16'hA5A5;
    end

    always @(posedge clk) begin
        pipe1    <= mem_rd_1 ? mem[mem_addr_1[7:0]] : 16'hDEAD;
        pipe3[0] <= mem_rd_3 ? mem[mem_addr_3[7:0]] : 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rddata_1 = pipe1;
    assign mem_rddata_3 = pipe3[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr,
                         input logic dw, input logic [15:0] da, input logic [15:0] dd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wrdata = dd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dd;
        logic        e_ig;
        logic        e_dg;
        logic        e_rd;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wd;
        logic        e_irv;
        logic [15:0] e_ird;
        logic        e_drv;
        logic [15:0] e_drd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        //          ir ia       dr dw da       dd        ig dg rd wr addr     wd       irv ird      drv drd
        vecs[0]  = '{1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000};
        vecs[1]  = '{1, 16'h0002, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0002, 16'h0000, 1, 16'h0100, 0, 16'h0000};
        vecs[2]  = '{1, 16'h0004, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0004, 16'h0000, 1, 16'h0102, 0, 16'h0000};
        vecs[3]  = '{1, 16'h0006, 1, 1, 16'h1000, 16'hBEEF, 0, 1, 0, 1, 16'h1000, 16'hBEEF, 1, 16'h0104, 0, 16'h0000};
        vecs[4]  = '{1, 16'h0006, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0006, 16'h0000, 0, 16'h0000, 0, 16'h0000};
        vecs[5]  = '{0, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 1, 1, 0, 16'h0040, 16'h0000, 1, 16'h0106, 0, 16'h0000};
        vecs[6]  = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 1, 16'h1234};
        vecs[7]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 0, 16'h0000};
        vecs[8]  = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000};
        vecs[9]  = '{0, 16'h0000, 1, 1, 16'h0022, 16'h1111, 0, 1, 0, 1, 16'h0022, 16'h1111, 0, 16'h0000, 0, 16'h0000};
        vecs[10] = '{0, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 1, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 0, 16'h0000};
        vecs[11] = '{0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'hA5A5};
    end

    initial begin
        logic [9:0] starve_i;
        logic [4:0] post_rst_i;
        reset = 1'b1;
        drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
        #1;
        #12;
        @(negedge clk);
        chk("reset_if_gnt", {31'b0, if_gnt_1}, 0);
        chk("reset_d_gnt", {31'b0, d_gnt_1}, 0);
        chk("reset_strobes", {30'b0, mem_rd_1, mem_wr_1}, 0);
        chk("reset_rvalid", {30'b0, if_rvalid_1, d_rvalid_1}, 0);
        chk("reset_addr", {16'b0, mem_addr_1}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fetch stream, write priority, mixed-requester routing, rdata gating.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
            @(negedge clk);
            chk($sformatf("v%0d_if_gnt", i), {31'b0, if_gnt_1}, {31'b0, vecs[i].e_ig});
            chk($sformatf("v%0d_d_gnt", i), {31'b0, d_gnt_1}, {31'b0, vecs[i].e_dg});
            chk($sformatf("v%0d_mem_rd", i), {31'b0, mem_rd_1}, {31'b0, vecs[i].e_rd});
            chk($sformatf("v%0d_mem_wr", i), {31'b0, mem_wr_1}, {31'b0, vecs[i].e_wr});
            chk($sformatf("v%0d_mem_addr", i), {16'b0, mem_addr_1}, {16'b0, vecs[i].e_addr});
            if (vecs[i].e_wr || !(vecs[i].e_ig || vecs[i].e_dg))
                chk($sformatf("v%0d_mem_wrdata", i), {16'b0, mem_wrdata_1}, {16'b0, vecs[i].e_wd});
            chk($sformatf("v%0d_if_rvalid", i), {31'b0, if_rvalid_1}, {31'b0, vecs[i].e_irv});
            chk($sformatf("v%0d_if_rdata", i), {16'b0, if_rdata_1}, {16'b0, vecs[i].e_ird});
            chk($sformatf("v%0d_d_rvalid", i), {31'b0, d_rvalid_1}, {31'b0, vecs[i].e_drv});
            chk($sformatf("v%0d_d_rdata", i), {16'b0, d_rdata_1}, {16'b0, vecs[i].e_drd});
            next_cycle();
        end

        // Starvation guard: D,D,D,D,I,D,D,D,D,I (bit i set = fetch granted).
        starve_i = 10'b10_0001_0000;
        drive(1, 16'h0030, 1, 0, 16'h0020, 16'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("starve%0d_if_gnt", i), {31'b0, if_gnt_1}, {31'b0, starve_i[i]});
            chk($sformatf("starve%0d_d_gnt", i), {31'b0, d_gnt_1}, {31'b0, !starve_i[i]});
            next_cycle();
        end

        // Latency-3 instance: single data read at cycle n returns at n+3 only.
        drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) next_cycle();
        drive(0, 16'h0, 1, 0, 16'h0040, 16'h0);
        @(negedge clk);
        chk("lat3_issue_gnt", {31'b0, d_gnt_3}, 1);
        next_cycle();
        drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("lat3_n%0d_d_rvalid", k), {31'b0, d_rvalid_3}, {31'b0, k == 3});
            chk($sformatf("lat3_n%0d_d_rdata", k), {16'b0, d_rdata_3}, (k == 3) ? 32'h1234 : 32'h0);
            chk($sformatf("lat3_n%0d_if_rvalid", k), {31'b0, if_rvalid_3}, 0);
            next_cycle();
        end

        // Reset mid-flight: contended data read at n, reset pulse during n+1.
        drive(1, 16'h0008, 1, 0, 16'h0040, 16'h0);
        @(negedge clk);
        chk("midrst_issue_gnt", {31'b0, d_gnt_3}, 1);
        next_cycle();
        drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_lat1_d_rvalid", {31'b0, d_rvalid_1}, 0);
        chk("midrst_lat1_d_rdata", {16'b0, d_rdata_1}, 0);
        next_cycle();
        reset = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("midrst_n%0d_rvalid3", k), {30'b0, if_rvalid_3, d_rvalid_3}, 0);
            chk($sformatf("midrst_n%0d_rvalid1", k), {30'b0, if_rvalid_1, d_rvalid_1}, 0);
            next_cycle();
        end

        // Streak cleared by reset: full four data grants before fetch is forced.
        post_rst_i = 5'b1_0000;
        drive(1, 16'h0008, 1, 0, 16'h0020, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d_if_gnt", i), {31'b0, if_gnt_3}, {31'b0, post_rst_i[i]});
            next_cycle();
        end

        // Lone fetch request is granted immediately.
        drive(1, 16'h000A, 0, 0, 16'h0, 16'h0);
        @(negedge clk);
        chk("postrst_fetch_gnt", {31'b0, if_gnt_3}, 1);
        chk("postrst_fetch_addr", {16'b0, mem_addr_3}, 32'h000A);
        next_cycle();
        drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
